// File: rtl/ir_nec_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_decoder
// Description : NEC infrared frame decoder. Synchronises and glitch-filters
//               the raw IR line, times each filtered pulse against windows
//               scaled from CLK_HZ, decodes 32-bit frames and repeat codes,
//               and presents frames through a ready/ack handshake with
//               overrun and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_decoder #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int GLITCH_CYC = 8,
    parameter int CHECK_CMD  = 1,
    parameter int CHECK_ADDR = 0,
    parameter int REPEAT_EN  = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iIRDA,
    input  logic        iACK,
    output logic [31:0] oDATA,
    output logic        oDATA_READY,
    output logic        oREPEAT,
    output logic        oERROR,
    output logic        oOVERRUN
);

    // Timing windows are scaled through kHz so that CLK_HZ*us/1e6 stays exact
    // for MHz clocks and still gives usable windows for sub-MHz clocks.
    localparam longint C_KHZ = longint'(CLK_HZ) / 1000;
    localparam int     C_SAT = int'(C_KHZ * 20000 / 1000);
    localparam int     CW    = $clog2(C_SAT + 1);
    localparam int     FW    = $clog2(GLITCH_CYC + 1);

    localparam logic [CW-1:0] C_SAT_CYC      = CW'(C_SAT);
    localparam logic [CW-1:0] C_LEAD_L_MIN   = CW'(C_KHZ * 8000  / 1000);
    localparam logic [CW-1:0] C_LEAD_L_MAX   = CW'(C_KHZ * 10000 / 1000);
    localparam logic [CW-1:0] C_LEAD_HD_MIN  = CW'(C_KHZ * 4000  / 1000);
    localparam logic [CW-1:0] C_LEAD_HD_MAX  = CW'(C_KHZ * 5000  / 1000);
    localparam logic [CW-1:0] C_LEAD_HR_MIN  = CW'(C_KHZ * 1750  / 1000);
    localparam logic [CW-1:0] C_LEAD_HR_MAX  = CW'(C_KHZ * 2750  / 1000);
    localparam logic [CW-1:0] C_BIT_L_MIN    = CW'(C_KHZ * 400   / 1000);
    localparam logic [CW-1:0] C_BIT_L_MAX    = CW'(C_KHZ * 760   / 1000);
    localparam logic [CW-1:0] C_BIT_H0_MIN   = CW'(C_KHZ * 400   / 1000);
    localparam logic [CW-1:0] C_BIT_H0_MAX   = CW'(C_KHZ * 800   / 1000);
    localparam logic [CW-1:0] C_BIT_H1_MIN   = CW'(C_KHZ * 1400  / 1000);
    localparam logic [CW-1:0] C_BIT_H1_MAX   = CW'(C_KHZ * 1900  / 1000);
    localparam logic [FW-1:0] C_GLITCH_LAST  = FW'(GLITCH_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEAD_L = 4'd1,
        S_LEAD_H = 4'd2,
        S_BIT_L  = 4'd3,
        S_BIT_H  = 4'd4,
        S_STOP_L = 4'd5,
        S_RPT_L  = 4'd6,
        S_ACCEPT = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   data_q, data_d;
    logic          ready_q, ready_d;
    logic          have_q, have_d;
    logic          repeat_q, repeat_d;
    logic          error_q, error_d;
    logic          overrun_q, overrun_d;

    logic w_rise, w_fall, w_edge;
    logic w_in_lead_l, w_in_lead_hd, w_in_lead_hr, w_in_bit_l, w_in_h0, w_in_h1;
    logic w_check_ok, w_timeout;

    // Two-flop synchroniser, glitch filter and edge history (line idles high).
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= iIRDA;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
        end
    end

    // Accept a new level only after GLITCH_CYC consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == C_GLITCH_LAST) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    assign w_rise = filt_q & ~filt_prev_q;
    assign w_fall = ~filt_q & filt_prev_q;
    assign w_edge = w_rise | w_fall;

    // Pulse-length counter: cleared on each filtered edge, saturates at 20 ms.
    always_comb begin
        cnt_d = cnt_q;
        if (w_edge) begin
            cnt_d = '0;
        end else if (cnt_q != C_SAT_CYC) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign w_in_lead_l  = (cnt_q >= C_LEAD_L_MIN)  && (cnt_q <= C_LEAD_L_MAX);
    assign w_in_lead_hd = (cnt_q >= C_LEAD_HD_MIN) && (cnt_q <= C_LEAD_HD_MAX);
    assign w_in_lead_hr = (cnt_q >= C_LEAD_HR_MIN) && (cnt_q <= C_LEAD_HR_MAX);
    assign w_in_bit_l   = (cnt_q >= C_BIT_L_MIN)   && (cnt_q <= C_BIT_L_MAX);
    assign w_in_h0      = (cnt_q >= C_BIT_H0_MIN)  && (cnt_q <= C_BIT_H0_MAX);
    assign w_in_h1      = (cnt_q >= C_BIT_H1_MIN)  && (cnt_q <= C_BIT_H1_MAX);

    assign w_check_ok = ((CHECK_CMD == 0)  || (shift_q[31:24] == ~shift_q[23:16])) &&
                        ((CHECK_ADDR == 0) || (shift_q[15:8]  == ~shift_q[7:0]));

    // ACCEPT and ERR last one cycle, so only the pulse-timing states can time out.
    assign w_timeout = (cnt_q == C_SAT_CYC) && (state_q != S_IDLE) &&
                       (state_q != S_ACCEPT) && (state_q != S_ERR);

    // Decoder state, frame buffer and registered output pulses.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            have_q    <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            have_q    <= have_d;
            repeat_q  <= repeat_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: each filtered edge judges the pulse that just ended.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;
        have_d    = have_q;
        repeat_d  = 1'b0;
        error_d   = 1'b0;
        overrun_d = 1'b0;

        if (ready_q && iACK) begin
            ready_d = 1'b0;
        end

        if (w_timeout) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_fall) state_d = S_LEAD_L;
                end
                S_LEAD_L: begin
                    if (w_rise) state_d = w_in_lead_l ? S_LEAD_H : S_ERR;
                end
                S_LEAD_H: begin
                    if (w_fall) begin
                        if (w_in_lead_hd) begin
                            state_d   = S_BIT_L;
                            bit_idx_d = '0;
                        end else if ((REPEAT_EN != 0) && w_in_lead_hr) begin
                            state_d = S_RPT_L;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_BIT_L: begin
                    if (w_rise) state_d = w_in_bit_l ? S_BIT_H : S_ERR;
                end
                S_BIT_H: begin
                    if (w_fall) begin
                        if (w_in_h0 || w_in_h1) begin
                            // LSB first: new bit enters at the top and moves down.
                            shift_d   = {w_in_h1, shift_q[31:1]};
                            bit_idx_d = bit_idx_q + 5'd1;
                            state_d   = (bit_idx_q == 5'd31) ? S_STOP_L : S_BIT_L;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_STOP_L: begin
                    if (w_rise) state_d = (w_in_bit_l && w_check_ok) ? S_ACCEPT : S_ERR;
                end
                S_RPT_L: begin
                    if (w_rise) begin
                        if (w_in_bit_l && have_q) begin
                            repeat_d = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_ACCEPT: begin
                    // A same-cycle ack frees the buffer, so the new frame loads.
                    have_d  = 1'b1;
                    state_d = S_IDLE;
                    if (!ready_q || iACK) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                S_ERR: begin
                    error_d = 1'b1;
                    have_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign oDATA       = data_q;
    assign oDATA_READY = ready_q;
    assign oREPEAT     = repeat_q;
    assign oERROR      = error_q;
    assign oOVERRUN    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_nec_decoder
// Description : Directed self-checking bench for ir_nec_decoder. A 50 kHz
//               clock gives 20 us per cycle, so NEC pulses are short in
//               cycles: leader 450/225, repeat high 112, bit low 28,
//               '0' high 28, '1' high 84.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_nec_decoder;

    logic        clk;
    logic        rst_n;
    logic        irda;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        rpt;
    logic        err;
    logic        ovr;

    int vectors;
    int miscompares;
    int n_err;
    int n_rpt;
    int n_ovr;

    ir_nec_decoder #(
        .CLK_HZ    (50_000),
        .GLITCH_CYC(8),
        .CHECK_CMD (1),
        .CHECK_ADDR(1),
        .REPEAT_EN (1)
    ) dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iIRDA      (irda),
        .iACK       (ack),
        .oDATA      (data),
        .oDATA_READY(ready),
        .oREPEAT    (rpt),
        .oERROR     (err),
        .oOVERRUN   (ovr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count output-high cycles; a correct pulse adds exactly one.
    always @(negedge clk) begin
        if (err) n_err++;
        if (rpt) n_rpt++;
        if (ovr) n_ovr++;
    end

    task automatic drive(input logic lvl, input int cycles);
        irda = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends the leader and the first nbits data bits; the stop bit only for a full frame.
    task automatic send_frame(input logic [31:0] f, input int nbits, input bit glitch);
        drive(1'b0, 450);
        drive(1'b1, 225);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, 28);
            if (glitch) begin
                drive(1'b1, f[i] ? 40 : 12);
                drive(1'b0, 2);
                drive(1'b1, f[i] ? 42 : 14);
            end else begin
                drive(1'b1, f[i] ? 84 : 28);
            end
        end
        if (nbits == 32) begin
            drive(1'b0, 28);
            drive(1'b1, 40);
        end
    endtask

    task automatic send_repeat();
        drive(1'b0, 450);
        drive(1'b1, 112);
        drive(1'b0, 28);
        drive(1'b1, 40);
    endtask

    task automatic test_reset();
        irda  = 1'b1;
        ack   = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected %h", data, 32'h0);
        end
        vectors++;
        if ({ready, rpt, err, ovr} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected %b", {ready, rpt, err, ovr}, 4'b0000);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_repeat_no_frame();
        int e0, r0;
        e0 = n_err;
        r0 = n_rpt;
        send_repeat();
        vectors++;
        if (n_err - e0 !== 1) begin
            miscompares++;
            $display("FAIL rpt_noframe_err: got %0d pulses expected %0d", n_err - e0, 1);
        end
        vectors++;
        if (n_rpt - r0 !== 0) begin
            miscompares++;
            $display("FAIL rpt_noframe_rpt: got %0d pulses expected %0d", n_rpt - r0, 0);
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] exp);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_ready: got %b expected %b", name, ready, 1'b1);
        end
        vectors++;
        if (data !== exp) begin
            miscompares++;
            $display("FAIL %s_data: got %h expected %h", name, data, exp);
        end
    endtask

    task automatic do_ack(input string name, input logic [31:0] exp);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ack_ready: got %b expected %b", name, ready, 1'b0);
        end
        vectors++;
        if (data !== exp) begin
            miscompares++;
            $display("FAIL %s_ack_hold: got %h expected %h", name, data, exp);
        end
    endtask

    task automatic test_basic_frame();
        int e0;
        e0 = n_err;
        send_frame(32'hBA45FF00, 32, 1'b0);
        check_frame("basic", 32'hBA45FF00);
        vectors++;
        if (n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL basic_err: got %0d pulses expected %0d", n_err - e0, 0);
        end
        do_ack("basic", 32'hBA45FF00);
    endtask

    task automatic test_bad_cmd();
        int e0;
        e0 = n_err;
        send_frame(32'hBB45FF00, 32, 1'b0);
        vectors++;
        if (n_err - e0 !== 1) begin
            miscompares++;
            $display("FAIL badcmd_err: got %0d pulses expected %0d", n_err - e0, 1);
        end
        vectors++;
        if (ready !== 1'b0 || data !== 32'hBA45FF00) begin
            miscompares++;
            $display("FAIL badcmd_out: got ready=%b data=%h expected ready=0 data=%h",
                     ready, data, 32'hBA45FF00);
        end
    endtask

    task automatic test_repeat();
        int e0, r0;
        send_frame(32'hED12CB34, 32, 1'b0);
        check_frame("rptframe", 32'hED12CB34);
        drive(1'b1, 1000);
        e0 = n_err;
        r0 = n_rpt;
        send_repeat();
        vectors++;
        if (n_rpt - r0 !== 1) begin
            miscompares++;
            $display("FAIL repeat_pulse: got %0d pulses expected %0d", n_rpt - r0, 1);
        end
        vectors++;
        if (n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL repeat_err: got %0d pulses expected %0d", n_err - e0, 0);
        end
        check_frame("repeat_hold", 32'hED12CB34);
        do_ack("repeat", 32'hED12CB34);
    endtask

    task automatic test_glitch();
        int e0;
        e0 = n_err;
        send_frame(32'h9F60F708, 32, 1'b1);
        check_frame("glitch", 32'h9F60F708);
        vectors++;
        if (n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_err: got %0d pulses expected %0d", n_err - e0, 0);
        end
        do_ack("glitch", 32'h9F60F708);
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = n_ovr;
        send_frame(32'hFE01FD02, 32, 1'b0);
        check_frame("b2b_first", 32'hFE01FD02);
        drive(1'b1, 200);
        send_frame(32'hF708EF10, 32, 1'b0);
        vectors++;
        if (n_ovr - o0 !== 1) begin
            miscompares++;
            $display("FAIL overrun_pulse: got %0d pulses expected %0d", n_ovr - o0, 1);
        end
        check_frame("b2b_keep", 32'hFE01FD02);
        do_ack("b2b", 32'hFE01FD02);
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_frame(32'hE31CBF40, 17, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        irda  = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready, data} !== 33'h0) begin
            miscompares++;
            $display("FAIL midreset_clear: got ready=%b data=%h expected 0", ready, data);
        end
        rst_n = 1'b1;
        e0 = n_err;
        drive(1'b1, 50);
        send_frame(32'hE31CBF40, 32, 1'b0);
        check_frame("midreset", 32'hE31CBF40);
        vectors++;
        if (n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_err: got %0d pulses expected %0d", n_err - e0, 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_err       = 0;
        n_rpt       = 0;
        n_ovr       = 0;
        irda        = 1'b1;
        ack         = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_repeat_no_frame();
        test_basic_frame();
        test_bad_cmd();
        test_repeat();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
